digit_scanner: RTL and testbench

DIGIT_SCANNER -- requirements
Module: digit_scanner

---
 rtl/digit_scanner_pkg.sv | 22 ++
 rtl/digit_scanner_scan_timer.sv | 46 ++++
 rtl/digit_scanner.sv | 150 +++++++++++++++
 tb/tb_digit_scanner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/digit_scanner_pkg.sv
// digit_scanner_pkg
//   Shared definitions for the multiplexed 4-digit display scanner:
//   the BLANK/SHOW scan state, the all-anodes-off pattern, default timing
//   values and a helper that builds the one-hot-low anode pattern.
//   Optional build macro used by the scanner: DIGIT_SCANNER_LZB_EN.
package digit_scanner_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [3:0] ANODES_OFF       = 4'hF;
  localparam int         DEF_PRESCALE     = 50000;
  localparam int         DEF_BLANK_CYCLES = 1000;

  // Active-low drive for a single digit: bit sel low, all others high.
  function automatic logic [3:0] anode_onehot_low(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/digit_scanner_scan_timer.sv
// scan_timer
//   Per-slot cycle counter for the display scanner. Counts 0..PRESCALE-1
//   and wraps; flags the last cycle of the slot and the last blank cycle.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (count back to 0)
//   slot_end   out  high while count == PRESCALE-1 (next edge starts a slot)
//   blank_done out  high while count == BLANK_CYCLES-1 (next edge enters SHOW)
module scan_timer
  import digit_scanner_pkg::*;
#(
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic blank_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= PRESCALE) begin : g_bad_cfg
    $error("scan_timer: BLANK_CYCLES must lie in 1..PRESCALE-1");
  end

  logic [CNT_W-1:0] count_q, count_d;

  assign slot_end   = (count_q == CNT_LAST);
  assign blank_done = (count_q == BLANK_LAST);

  always_comb begin
    count_d = slot_end ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/digit_scanner.sv
// digit_scanner
//   Time-multiplexes four hex digits onto a common-anode display. Each digit
//   owns a slot of PRESCALE cycles; the first BLANK_CYCLES cycles of every
//   slot keep all anodes off to hide segment switching (ghosting). New
//   display data is staged in a pending register and only becomes active on
//   the frame wrap (digit 3 -> digit 0), so a frame never mixes two values.
//   Optional: define DIGIT_SCANNER_LZB_EN for leading-zero blanking.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   value[15:0] in   four nibbles, digit i = value[4i+3:4i]
//   value_load  in   one-cycle strobe to take value and dots_in
//   dots_in[3:0]in   decimal points, one per digit
//   digit_en[3:0]in  live per-digit enable mask
//   dig_sel[1:0]out  digit currently scanned
//   nibble[3:0] out  active nibble of dig_sel (to hex decoder)
//   dots[3:0]   out  active decimal-point word
//   anodes[3:0] out  active-low digit drives
//   frame_tick  out  one-cycle pulse in the first cycle after a frame wrap
module digit_scanner
  import digit_scanner_pkg::*;
#(
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        value_load,
  input  logic [3:0]  dots_in,
  input  logic [3:0]  digit_en,
  output logic [1:0]  dig_sel,
  output logic [3:0]  nibble,
  output logic [3:0]  dots,
  output logic [3:0]  anodes,
  output logic        frame_tick
);

  logic slot_end;
  logic blank_done;

  scan_timer #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_scan_timer (
    .clk       (clk),
    .rst       (rst),
    .slot_end  (slot_end),
    .blank_done(blank_done)
  );

  scan_state_e state_q, state_d;
  logic [1:0]  dig_sel_q, dig_sel_d;
  logic [3:0]  nibble_q, nibble_d;
  logic [15:0] act_val_q, act_val_d;
  logic [3:0]  act_dots_q, act_dots_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dots_q, pend_dots_d;
  logic        pend_vld_q, pend_vld_d;
  logic        frame_tick_q, frame_tick_d;
  logic        wrap;
  logic        lit;

  // Frame wrap: last cycle of the digit-3 slot.
  assign wrap = slot_end && (dig_sel_q == 2'd3);

  always_comb begin
    state_d = state_q;
    if (slot_end) begin
      state_d = ST_BLANK;
    end else if (blank_done) begin
      state_d = ST_SHOW;
    end

    dig_sel_d = slot_end ? dig_sel_q + 2'd1 : dig_sel_q;

    act_val_d   = act_val_q;
    act_dots_d  = act_dots_q;
    pend_val_d  = pend_val_q;
    pend_dots_d = pend_dots_q;
    pend_vld_d  = pend_vld_q;

    if (wrap) begin
      // A load on the wrap edge itself goes straight to active; it is newer
      // than anything sitting in pending.
      if (value_load) begin
        act_val_d  = value;
        act_dots_d = dots_in;
      end else if (pend_vld_q) begin
        act_val_d  = pend_val_q;
        act_dots_d = pend_dots_q;
      end
      pend_vld_d = 1'b0;
    end else if (value_load) begin
      pend_val_d  = value;
      pend_dots_d = dots_in;
      pend_vld_d  = 1'b1;
    end

    // Look ahead through the next-state values so the nibble lands on the
    // same edge as dig_sel, including the edge where active is replaced.
    nibble_d     = act_val_d[{dig_sel_d, 2'b00} +: 4];
    frame_tick_d = wrap;
  end

  always_comb begin
    lit = (state_q == ST_SHOW) && digit_en[dig_sel_q];
`ifdef DIGIT_SCANNER_LZB_EN
    // A digit is a leading zero when it and every higher nibble are zero;
    // a set decimal point keeps it visible. Digit 0 always shows.
    unique case (dig_sel_q)
      2'd3:    lit = lit && !((act_val_q[15:12] == 4'h0)  && !act_dots_q[3]);
      2'd2:    lit = lit && !((act_val_q[15:8]  == 8'h00) && !act_dots_q[2]);
      2'd1:    lit = lit && !((act_val_q[15:4]  == 12'h000) && !act_dots_q[1]);
      default: lit = lit;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      dig_sel_q    <= 2'd0;
      nibble_q     <= 4'h0;
      act_val_q    <= 16'h0000;
      act_dots_q   <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_dots_q  <= 4'h0;
      pend_vld_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dig_sel_q    <= dig_sel_d;
      nibble_q     <= nibble_d;
      act_val_q    <= act_val_d;
      act_dots_q   <= act_dots_d;
      pend_val_q   <= pend_val_d;
      pend_dots_q  <= pend_dots_d;
      pend_vld_q   <= pend_vld_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign dig_sel    = dig_sel_q;
  assign nibble     = nibble_q;
  assign dots       = act_dots_q;
  assign anodes     = lit ? anode_onehot_low(dig_sel_q) : ANODES_OFF;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_digit_scanner.sv
// tb_digit_scanner
//   Frame-level bench for digit_scanner with PRESCALE=8, BLANK_CYCLES=2.
//   Each table record is loaded during one frame and pushed to a scoreboard;
//   the record is popped at the next frame start and every cycle of that
//   frame is compared. Expected anode patterns follow DIGIT_SCANNER_LZB_EN.
module tb_digit_scanner;

  localparam int PRESCALE     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 4 * PRESCALE;
  localparam int NV           = 8;

  // Anode patterns packed per slot: slot i at [4i+3:4i].
  localparam logic [15:0] AN_ALL = 16'h7BDE;
`ifdef DIGIT_SCANNER_LZB_EN
  localparam logic [15:0] AN_ZERO = 16'hFFFE;
  localparam logic [15:0] AN_0007 = 16'hFBFE;
  localparam logic [15:0] AN_00F0 = 16'hFFDE;
`else
  localparam logic [15:0] AN_ZERO = AN_ALL;
  localparam logic [15:0] AN_0007 = AN_ALL;
  localparam logic [15:0] AN_00F0 = AN_ALL;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        value_load = 1'b0;
  logic [3:0]  dots_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic [1:0]  dig_sel;
  logic [3:0]  nibble;
  logic [3:0]  dots;
  logic [3:0]  anodes;
  logic        frame_tick;

  digit_scanner #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .value_load(value_load),
    .dots_in   (dots_in),
    .digit_en  (digit_en),
    .dig_sel   (dig_sel),
    .nibble    (nibble),
    .dots      (dots),
    .anodes    (anodes),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] decoy_val;
    logic [3:0]  decoy_dots;
    logic [15:0] val;
    logic [3:0]  dts;
    logic [3:0]  en;
    logic [15:0] exp_an;
    bit          on_wrap;
  } vec_t;

  vec_t vecs[NV];
  vec_t rzero;
  vec_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    value      = v;
    dots_in    = d;
    value_load = 1'b1;
  endtask

  // Entered at the negedge of cycle 0 of a frame; leaves at the negedge of
  // cycle 0 of the following frame.
  task automatic run_frame(input bit tick0, input bit do_load, input vec_t ld);
    vec_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue, want one record");
      e = rzero;
    end else begin
      e = sb.pop_front();
    end
    for (int c = 0; c < FRAME; c++) begin
      int s;
      int k;
      s = c / PRESCALE;
      k = c % PRESCALE;
      chk("dig_sel", 16'(dig_sel), 16'(s));
      chk("nibble", 16'(nibble), 16'(e.val[4*s +: 4]));
      chk("dots", 16'(dots), 16'(e.dts));
      chk("anodes", 16'(anodes), (k < BLANK_CYCLES) ? 16'h000F : 16'(e.exp_an[4*s +: 4]));
      chk("frame_tick", 16'(frame_tick), (c == 0) ? 16'(tick0) : 16'h0000);
      value_load = 1'b0;
      if (c == 0) digit_en = e.en;
      if (do_load) begin
        if (!ld.on_wrap && c == PRESCALE + 2) load(ld.decoy_val, ld.decoy_dots);
        if (!ld.on_wrap && c == 2 * PRESCALE + 2) begin
          load(ld.val, ld.dts);
          sb.push_back(ld);
        end
        if (ld.on_wrap && c == FRAME - 1) begin
          load(ld.val, ld.dts);
          sb.push_back(ld);
        end
      end
      @(negedge clk);
    end
    value_load = 1'b0;
  endtask

  initial begin
    rzero   = '{16'h0000, 4'h0, 16'h0000, 4'h0, 4'hF, AN_ZERO, 1'b0};
    vecs[0] = '{16'hEEEE, 4'hF, 16'h1234, 4'h0, 4'hF, AN_ALL,  1'b0};
    vecs[1] = '{16'hABCD, 4'h0, 16'h5678, 4'h0, 4'hF, AN_ALL,  1'b0};
    vecs[2] = '{16'h1111, 4'h1, 16'h9ABC, 4'h3, 4'h5, 16'hFBFE, 1'b0};
    vecs[3] = '{16'hFFFF, 4'h0, 16'h0007, 4'h4, 4'hF, AN_0007, 1'b0};
    vecs[4] = '{16'h1234, 4'h0, 16'h0F00, 4'h8, 4'hF, AN_ALL,  1'b0};
    vecs[5] = '{16'h0000, 4'h0, 16'h00F0, 4'h0, 4'hF, AN_00F0, 1'b1};
    vecs[6] = '{16'h4321, 4'h2, 16'h0000, 4'h0, 4'hF, AN_ZERO, 1'b0};
    vecs[7] = '{16'h0001, 4'h0, 16'h8421, 4'h0, 4'h0, 16'hFFFF, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dig_sel", 16'(dig_sel), 16'h0000);
    chk("rst_nibble", 16'(nibble), 16'h0000);
    chk("rst_dots", 16'(dots), 16'h0000);
    chk("rst_anodes", 16'(anodes), 16'h000F);
    chk("rst_frame_tick", 16'(frame_tick), 16'h0000);
    rst = 1'b0;

    sb.push_back(rzero);
    run_frame(1'b0, 1'b1, vecs[0]);
    for (int i = 1; i < NV; i++) run_frame(1'b1, 1'b1, vecs[i]);
    run_frame(1'b1, 1'b0, rzero);

    // Reset at count 5 of slot 2 with a load still pending.
    for (int c = 0; c < 2 * PRESCALE + 5; c++) begin
      value_load = 1'b0;
      if (c == PRESCALE + 2) load(16'hBEEF, 4'hA);
      @(negedge clk);
    end
    value_load = 1'b0;
    chk("pre_rst_dig_sel", 16'(dig_sel), 16'h0002);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_anodes", 16'(anodes), 16'h000F);
    chk("mid_rst_dig_sel", 16'(dig_sel), 16'h0000);
    chk("mid_rst_nibble", 16'(nibble), 16'h0000);
    chk("mid_rst_dots", 16'(dots), 16'h0000);
    chk("mid_rst_frame_tick", 16'(frame_tick), 16'h0000);
    rst = 1'b0;

    // Active and pending must both be cleared: two blank-value frames.
    sb.push_back(rzero);
    run_frame(1'b0, 1'b0, rzero);
    sb.push_back(rzero);
    run_frame(1'b1, 1'b0, rzero);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
